pipeline_hazard_ctrl: RTL and testbench

Stall and bubble scheduler for the 5-stage pipeline. It sits beside the ID-stage GPR bypass network and detects cases the bypass cannot cover: a producer whose result is not yet available in EXE or MEM, a busy multi-cycle divider, and data-memory wait. It drives PC/IF-ID freeze, ID-EXE bubble insertion and whole-pipe freeze. It also sequences divider start and occupancy and keeps a stall-cycle performance counter.

---
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble scheduler for the 5-stage pipeline: GPR hazards the bypass cannot cover,
// multi-cycle divider sequencing, data-memory wait freeze and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned DIV_LATENCY = 32,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_ID_raddr1,
    input  logic [4:0]       i_ID_raddr2,
    input  logic             i_ID_use_rs1,
    input  logic             i_ID_use_rs2,
    input  logic             i_ID_is_div,
    input  logic             i_ID_uses_hilo,
    input  logic             i_EXE_wen,
    input  logic [4:0]       i_EXE_waddr,
    input  logic             i_EXE_get_result_in_EXE,
    input  logic             i_MEM_wen,
    input  logic [4:0]       i_MEM_waddr,
    input  logic             i_MEM_get_result_in_MEM,
    input  logic             i_MEM_stall,
    input  logic             i_exception,
    output logic             o_PC_stall,
    output logic             o_IF_ID_stall,
    output logic             o_ID_EXE_bubble,
    output logic             o_pipe_freeze,
    output logic             o_div_start,
    output logic             o_div_busy,
    output logic [CNT_W-1:0] o_stall_cycles
);

    localparam logic [5:0] DivLoad = 6'(DIV_LATENCY - 1);

    typedef enum logic {StIdle, StDivRun} state_e;

    state_e           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs1_live, rs2_live;
    logic raw_exe, raw_mem, data_haz, div_haz;

    assign rs1_live = i_ID_use_rs1 && (i_ID_raddr1 != 5'd0);
    assign rs2_live = i_ID_use_rs2 && (i_ID_raddr2 != 5'd0);

    assign raw_exe = i_EXE_wen && !i_EXE_get_result_in_EXE &&
                     ((rs1_live && (i_ID_raddr1 == i_EXE_waddr)) ||
                      (rs2_live && (i_ID_raddr2 == i_EXE_waddr)));
    assign raw_mem = i_MEM_wen && !i_MEM_get_result_in_MEM &&
                     ((rs1_live && (i_ID_raddr1 == i_MEM_waddr)) ||
                      (rs2_live && (i_ID_raddr2 == i_MEM_waddr)));

    // Hazards are masked while reset is held so only a memory wait can show through.
    assign data_haz = rst_n && (raw_exe || raw_mem);

    // Final divider cycle releases HI/LO consumers: results land at the next edge.
    assign div_haz = (i_ID_is_div || i_ID_uses_hilo) && o_div_busy && (cnt_q != 6'd0);

    assign o_div_busy     = (state_q == StDivRun);
    assign o_stall_cycles = stall_cnt_q;

    always_comb begin
        o_PC_stall      = 1'b0;
        o_IF_ID_stall   = 1'b0;
        o_ID_EXE_bubble = 1'b0;
        o_pipe_freeze   = 1'b0;
        o_div_start     = 1'b0;
        if (i_exception) begin
            o_div_start = 1'b0;
        end else if (i_MEM_stall) begin
            o_pipe_freeze = 1'b1;
            o_PC_stall    = 1'b1;
            o_IF_ID_stall = 1'b1;
        end else if (data_haz || div_haz) begin
            o_PC_stall      = 1'b1;
            o_IF_ID_stall   = 1'b1;
            o_ID_EXE_bubble = 1'b1;
        end else begin
            o_div_start = rst_n && i_ID_is_div;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (o_div_start) begin
                    state_d = StDivRun;
                    cnt_d   = DivLoad;
                end
            end
            StDivRun: begin
                if (i_exception) begin
                    state_d = StIdle;
                    cnt_d   = 6'd0;
                end else if (cnt_q == 6'd0) begin
                    if (o_div_start) begin
                        cnt_d = DivLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_PC_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 6'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl; a narrow-counter copy checks saturation.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] raddr1, raddr2, ewaddr, mwaddr;
    logic       use1, use2, is_div, hilo, ewen, eget, mwen, mget, memst, exc;

    logic        pc, ifid, bub, frz, ds, db;
    logic [31:0] cnt;
    logic        s_pc, s_ifid, s_bub, s_frz, s_ds, s_db;
    logic [1:0]  s_cnt;

    // Output vector order: {pc, ifid, bubble, freeze, div_start, div_busy}
    localparam logic [5:0] S  = 6'b111000;
    localparam logic [5:0] F  = 6'b110100;
    localparam logic [5:0] DS = 6'b000010;
    localparam logic [5:0] DB = 6'b000001;

    typedef struct packed {
        logic [5:0]  outs;
        logic [31:0] cnt;
        logic [1:0]  sat;
        int unsigned id;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned exp_cnt  = 0;
    int unsigned vec_id   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DIV_LATENCY(4), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_ID_raddr1(raddr1), .i_ID_raddr2(raddr2),
        .i_ID_use_rs1(use1), .i_ID_use_rs2(use2),
        .i_ID_is_div(is_div), .i_ID_uses_hilo(hilo),
        .i_EXE_wen(ewen), .i_EXE_waddr(ewaddr), .i_EXE_get_result_in_EXE(eget),
        .i_MEM_wen(mwen), .i_MEM_waddr(mwaddr), .i_MEM_get_result_in_MEM(mget),
        .i_MEM_stall(memst), .i_exception(exc),
        .o_PC_stall(pc), .o_IF_ID_stall(ifid), .o_ID_EXE_bubble(bub),
        .o_pipe_freeze(frz), .o_div_start(ds), .o_div_busy(db),
        .o_stall_cycles(cnt)
    );

    pipeline_hazard_ctrl #(.DIV_LATENCY(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .i_ID_raddr1(raddr1), .i_ID_raddr2(raddr2),
        .i_ID_use_rs1(use1), .i_ID_use_rs2(use2),
        .i_ID_is_div(is_div), .i_ID_uses_hilo(hilo),
        .i_EXE_wen(ewen), .i_EXE_waddr(ewaddr), .i_EXE_get_result_in_EXE(eget),
        .i_MEM_wen(mwen), .i_MEM_waddr(mwaddr), .i_MEM_get_result_in_MEM(mget),
        .i_MEM_stall(memst), .i_exception(exc),
        .o_PC_stall(s_pc), .o_IF_ID_stall(s_ifid), .o_ID_EXE_bubble(s_bub),
        .o_pipe_freeze(s_frz), .o_div_start(s_ds), .o_div_busy(s_db),
        .o_stall_cycles(s_cnt)
    );

    // Monitor: one expected entry per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if ({pc, ifid, bub, frz, ds, db} !== e.outs) begin
                n_fail++;
                $display("FAIL outputs vec%0d: got %b want %b", e.id,
                         {pc, ifid, bub, frz, ds, db}, e.outs);
            end
            n_checks++;
            if (cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL stall_cycles vec%0d: got %0d want %0d", e.id, cnt, e.cnt);
            end
            n_checks++;
            if (s_cnt !== e.sat) begin
                n_fail++;
                $display("FAIL sat_counter vec%0d: got %0d want %0d", e.id, s_cnt, e.sat);
            end
        end
    end

    task automatic clr();
        raddr1 = 5'd0; raddr2 = 5'd0; ewaddr = 5'd0; mwaddr = 5'd0;
        use1 = 1'b0; use2 = 1'b0; is_div = 1'b0; hilo = 1'b0;
        ewen = 1'b0; eget = 1'b0; mwen = 1'b0; mget = 1'b0; memst = 1'b0; exc = 1'b0;
    endtask

    // Push the expectation for the current cycle, then advance one clock.
    task automatic step(input logic [5:0] o);
        exp_t e;
        if (!rst_n) exp_cnt = 0;
        e.outs = o;
        e.cnt  = exp_cnt;
        e.sat  = (exp_cnt > 3) ? 2'd3 : 2'(exp_cnt);
        e.id   = vec_id;
        vec_id++;
        sb.push_back(e);
        @(posedge clk);
        if (!rst_n) exp_cnt = 0;
        else if (o[5]) exp_cnt++;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        clr();
        @(posedge clk); #1;
        step(6'b0); step(6'b0);
        rst_n = 1'b1;
        step(6'b0);

        // Load-use: one bubble, then producer final in MEM
        clr(); ewen = 1; ewaddr = 5'd5; raddr1 = 5'd5; use1 = 1; step(S);
        clr(); mwen = 1; mwaddr = 5'd5; mget = 1; raddr1 = 5'd5; use1 = 1; step(6'b0);
        // $0 and unused operand
        clr(); ewen = 1; ewaddr = 5'd0; raddr1 = 5'd0; use1 = 1; step(6'b0);
        clr(); ewen = 1; ewaddr = 5'd7; raddr2 = 5'd7; use2 = 0; step(6'b0);
        use2 = 1; step(S);
        clr(); mwen = 1; mwaddr = 5'd9; raddr1 = 5'd9; use1 = 1; step(S);
        clr(); ewen = 1; ewaddr = 5'd9; eget = 1; raddr1 = 5'd9; use1 = 1; step(6'b0);

        // Divider: start, MFLO stalls 3 cycles then issues on the last busy cycle
        clr(); is_div = 1; step(DS);
        clr(); hilo = 1; step(S | DB); step(S | DB); step(S | DB); step(DB);
        clr(); step(6'b0);
        // Independent ADD during busy, back-to-back DIV on the last busy cycle
        clr(); is_div = 1; step(DS);
        clr(); raddr1 = 5'd1; use1 = 1; step(DB);
        clr(); step(DB); step(DB);
        is_div = 1; step(DS | DB);
        // Exception during DIV_RUN with a stalled MFHI
        clr(); hilo = 1; exc = 1; step(DB);
        clr(); hilo = 1; step(6'b0);
        // DIV blocked by a data hazard
        clr(); is_div = 1; ewen = 1; ewaddr = 5'd3; raddr1 = 5'd3; use1 = 1; step(S);

        // Memory wait over a load-use hazard: 3 freeze cycles then the bubble
        clr(); ewen = 1; ewaddr = 5'd5; raddr1 = 5'd5; use1 = 1; memst = 1;
        step(F); step(F); step(F);
        memst = 0; step(S);
        clr(); mwen = 1; mwaddr = 5'd5; mget = 1; raddr1 = 5'd5; use1 = 1; step(6'b0);
        // Exception beats memory stall; memory stall blocks div start
        clr(); memst = 1; exc = 1; ewen = 1; ewaddr = 5'd5; raddr1 = 5'd5; use1 = 1;
        step(6'b0);
        clr(); is_div = 1; memst = 1; step(F);
        clr(); is_div = 1; exc = 1; step(6'b0);

        // Async reset in the middle of a divide
        clr(); is_div = 1; step(DS);
        clr(); step(DB); step(DB);
        rst_n = 1'b0; step(6'b0);
        rst_n = 1'b1; step(6'b0);
        is_div = 1; step(DS);
        clr(); step(DB);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
